psram_rx_capture: RTL and testbench

Receive-side deserializer for the serial PSRAM interface. It sits directly downstream of the PSRAM command controller and watches the controller's chip-enable plus the chip's serial output (SO). For each framed transaction it discards a programmable number of command/address/dummy bit slots, then packs the remaining bits MSB-first into bytes. Bytes go to the consumer through a single-entry valid/ready holding register.

---
 rtl/psram_pkg.sv | 24 ++
 rtl/psram_rx_capture.sv | 172 +++++++++++++++++
 tb/tb_psram_rx_capture.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the serial PSRAM interface: receive FSM states,
// command opcodes and the number of bit slots preceding read data.
package psram_pkg;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        SKIP   = 2'd2,
        SHIFT  = 2'd3
    } rx_state_e;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_READ_ID   = 8'h9F;
    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_RESET_EN  = 8'h66;
    localparam logic [7:0] OP_RESET     = 8'h99;

    // Command + address (+ dummy) slots before the first data bit on SO.
    localparam int SKIP_READ      = 32;
    localparam int SKIP_FAST_READ = 40;
    localparam int SKIP_READ_ID   = 32;

endpackage

// File: rtl/psram_rx_capture.sv
// PSRAM receive deserializer: drops the leading command/address slots of each
// chip-enable frame, packs SO MSB-first into bytes, hands them out via valid/ready.
module psram_rx_capture
    import psram_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int SKIP_W = 6
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              psram_ce_n,
    input  logic              psram_so,
    input  logic [SKIP_W-1:0] skip_bits,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_bytes,
    output logic              frame_err,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              busy
);

    rx_state_e         state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shreg_q, shreg_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_vld_q, byte_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  frame_bytes_q, frame_bytes_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        state_d       = state_q;
        skip_d        = skip_q;
        skip_cnt_d    = skip_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        byte_d        = byte_q;
        byte_vld_d    = 1'b0;
        cnt_d         = cnt_q;
        frame_bytes_d = frame_bytes_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        overrun_d     = overrun_q;

        case (state_q)
            RESYNC: begin
                if (psram_ce_n) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!psram_ce_n) begin
                    skip_d     = skip_bits;
                    skip_cnt_d = SKIP_W'(1);
                    bit_cnt_d  = 3'd0;
                    cnt_d      = '0;
                    if (skip_bits == '0) begin
                        // No slots to skip: this strobe already carries data bit 7.
                        shreg_d   = {shreg_q[5:0], psram_so};
                        bit_cnt_d = 3'd1;
                        state_d   = SHIFT;
                    end else if (skip_bits == SKIP_W'(1)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = SKIP;
                    end
                end
            end
            SKIP: begin
                if (psram_ce_n) begin
                    state_d       = IDLE;
                    frame_done_d  = 1'b1;
                    frame_bytes_d = cnt_q;
                end else begin
                    skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                    if (skip_cnt_q + SKIP_W'(1) == skip_q) begin
                        bit_cnt_d = 3'd0;
                        state_d   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (psram_ce_n) begin
                    state_d       = IDLE;
                    frame_done_d  = 1'b1;
                    frame_err_d   = (bit_cnt_q != 3'd0);
                    frame_bytes_d = cnt_q;
                end else begin
                    shreg_d   = {shreg_q[5:0], psram_so};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_d     = {shreg_q, psram_so};
                        byte_vld_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = RESYNC;
        endcase

        // Holding register; a drop sets overrun even if ovr_clr is high.
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (byte_vld_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = byte_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q       <= RESYNC;
            skip_q        <= '0;
            skip_cnt_q    <= '0;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= 7'd0;
            byte_q        <= 8'd0;
            byte_vld_q    <= 1'b0;
            cnt_q         <= '0;
            frame_bytes_q <= '0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_q        <= skip_d;
            skip_cnt_q    <= skip_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            byte_q        <= byte_d;
            byte_vld_q    <= byte_vld_d;
            cnt_q         <= cnt_d;
            frame_bytes_q <= frame_bytes_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_bytes = frame_bytes_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q == SKIP) || (state_q == SHIFT);

endmodule

// File: tb/tb_psram_rx_capture.sv
// Directed self-checking bench for psram_rx_capture: inputs change 1ns after
// each rising edge, outputs are checked 1ns after the edge of interest.
module tb_psram_rx_capture;
    import psram_pkg::*;

    localparam int CNT_W  = 16;
    localparam int SKIP_W = 6;

    logic              sys_clk = 1'b0;
    logic              sys_reset;
    logic              psram_ce_n;
    logic              psram_so;
    logic [SKIP_W-1:0] skip_bits;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              frame_done;
    logic [CNT_W-1:0]  frame_bytes;
    logic              frame_err;
    logic              overrun;
    logic              ovr_clr;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]       rx_q[$];
    logic [CNT_W-1:0] fb_q[$];
    logic             fe_q[$];

    psram_rx_capture #(.CNT_W(CNT_W), .SKIP_W(SKIP_W)) dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .psram_ce_n  (psram_ce_n),
        .psram_so    (psram_so),
        .skip_bits   (skip_bits),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_done  (frame_done),
        .frame_bytes (frame_bytes),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Record every handshake and frame end, one line per transaction.
    always @(negedge sys_clk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            rx_q.push_back(rx_data);
            $display("[%0t] rx byte 0x%02h", $time, rx_data);
        end
        if (frame_done === 1'b1) begin
            fb_q.push_back(frame_bytes);
            fe_q.push_back(frame_err);
            $display("[%0t] frame_done bytes=%0d err=%0b", $time, frame_bytes, frame_err);
        end
    end

    task automatic clear_log();
        rx_q.delete();
        fb_q.delete();
        fe_q.delete();
    endtask

    task automatic send_bit(input logic b);
        psram_ce_n = 1'b0;
        psram_so   = b;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic ce_high(input int n);
        psram_ce_n = 1'b1;
        psram_so   = 1'b0;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        sys_reset = 1'b1;
        ce_high(3);
        sys_reset = 1'b0;
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (frame_bytes !== 16'd0) begin n_fail++; $display("FAIL reset_frame_bytes: got %0d expected 0", frame_bytes); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        ce_high(1);
    endtask

    task automatic test_normal_read();
        clear_log();
        rx_ready  = 1'b0;
        skip_bits = SKIP_W'(SKIP_READ);
        send_byte(OP_READ);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b expected 1", busy); end
        send_byte(8'hAB);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL read_latency_early: got %b expected 0", rx_valid); end
        ce_high(1);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL read_valid: got %b expected 1", rx_valid); end
        n_checks++; if (rx_data !== 8'hAB) begin n_fail++; $display("FAIL read_data: got %h expected ab", rx_data); end
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL read_frame_done: got %b expected 1", frame_done); end
        n_checks++; if (frame_bytes !== 16'd1) begin n_fail++; $display("FAIL read_frame_bytes: got %0d expected 1", frame_bytes); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL read_frame_err: got %b expected 0", frame_err); end
        rx_ready = 1'b1;
        ce_high(1);
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL read_done_pulse: got %b expected 0", frame_done); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL read_consume: got %b expected 0", rx_valid); end
        n_checks++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL read_beats: got %0d expected 1", rx_q.size()); end
    endtask

    task automatic test_read_id();
        logic [7:0] exp_b [6];
        logic [7:0] got;
        exp_b = '{8'h0D, 8'h5D, 8'hE2, 8'h33, 8'hC4, 8'hF0};
        clear_log();
        rx_ready  = 1'b1;
        skip_bits = SKIP_W'(SKIP_READ_ID);
        send_byte(OP_READ_ID);
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'hA5);
        for (int i = 0; i < 6; i++) send_byte(exp_b[i]);
        ce_high(3);
        n_checks++; if (rx_q.size() !== 6) begin n_fail++; $display("FAIL readid_beats: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_checks++; if (got !== exp_b[i]) begin n_fail++; $display("FAIL readid_byte%0d: got %h expected %h", i, got, exp_b[i]); end
        end
        n_checks++; if (fb_q.size() !== 1 || fb_q[0] !== 16'd6) begin n_fail++; $display("FAIL readid_frame_bytes: frames %0d bytes %0d expected 1 frame of 6", fb_q.size(), frame_bytes); end
    endtask

    task automatic test_partial_byte();
        clear_log();
        rx_ready  = 1'b1;
        skip_bits = '0;
        send_byte(8'hC3);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        ce_high(1);
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL partial_done: got %b expected 1", frame_done); end
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL partial_err: got %b expected 1", frame_err); end
        n_checks++; if (frame_bytes !== 16'd1) begin n_fail++; $display("FAIL partial_bytes: got %0d expected 1", frame_bytes); end
        ce_high(2);
        n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'hC3) begin n_fail++; $display("FAIL partial_data: beats %0d last %h expected 1 beat of c3", rx_q.size(), rx_data); end
        n_checks++; if (fe_q.size() !== 1) begin n_fail++; $display("FAIL partial_done_count: got %0d expected 1", fe_q.size()); end
    endtask

    task automatic test_overrun();
        clear_log();
        rx_ready  = 1'b0;
        skip_bits = '0;
        send_byte(8'h11);
        send_byte(8'h22);
        ce_high(1);
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_data_held: got %h expected 11", rx_data); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        ovr_clr = 1'b1;
        ce_high(1);
        ovr_clr = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        send_byte(8'h33);
        ovr_clr = 1'b1;
        ce_high(1);
        ovr_clr = 1'b0;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_priority: got %b expected 1", overrun); end
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_data_still: got %h expected 11", rx_data); end
        rx_ready = 1'b1;
        ce_high(2);
        n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h11) begin n_fail++; $display("FAIL ovr_drain: beats %0d expected 1 beat of 11", rx_q.size()); end
        ovr_clr = 1'b1;
        ce_high(1);
        ovr_clr = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        rx_ready  = 1'b1;
        skip_bits = SKIP_W'(8);
        for (int i = 0; i < 20; i++) send_bit(1'(i % 3 == 0));
        sys_reset = 1'b1;
        send_bit(1'b1);
        sys_reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (frame_bytes !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_bytes: got %0d expected 0", frame_bytes); end
        clear_log();
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_resync_busy: got %b expected 0", busy); end
        ce_high(3);
        n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d beats expected 0", rx_q.size()); end
        n_checks++; if (fb_q.size() !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d frames expected 0", fb_q.size()); end
        send_byte(OP_RESET_EN);
        send_byte(8'h5A);
        ce_high(3);
        n_checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h5A) begin n_fail++; $display("FAIL midrst_next_frame: beats %0d data %h expected 1 beat of 5a", rx_q.size(), rx_data); end
        n_checks++; if (fb_q.size() !== 1 || fb_q[0] !== 16'd1) begin n_fail++; $display("FAIL midrst_next_bytes: frames %0d bytes %0d expected 1 frame of 1", fb_q.size(), frame_bytes); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        rx_ready  = 1'b1;
        skip_bits = '0;
        send_byte(8'h96);
        ce_high(1);
        skip_bits = SKIP_W'(8);
        send_bit(1'b1);
        skip_bits = SKIP_W'(3);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        send_byte(8'h69);
        ce_high(3);
        n_checks++; if (rx_q.size() !== 2) begin n_fail++; $display("FAIL b2b_beats: got %0d expected 2", rx_q.size()); end
        n_checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'h96) begin n_fail++; $display("FAIL b2b_byte0: beats %0d expected first 96", rx_q.size()); end
        n_checks++; if (rx_q.size() < 2 || rx_q[1] !== 8'h69) begin n_fail++; $display("FAIL b2b_byte1: beats %0d expected second 69", rx_q.size()); end
        n_checks++; if (fb_q.size() !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", fb_q.size()); end
        n_checks++; if (fb_q.size() == 2 && (fb_q[0] !== 16'd1 || fb_q[1] !== 16'd1 || fe_q[0] !== 1'b0 || fe_q[1] !== 1'b0))
            begin n_fail++; $display("FAIL b2b_frame_info: bytes %0d/%0d err %b/%b expected 1/1 0/0", fb_q[0], fb_q[1], fe_q[0], fe_q[1]); end
    endtask

    initial begin
        sys_reset  = 1'b1;
        psram_ce_n = 1'b1;
        psram_so   = 1'b0;
        skip_bits  = '0;
        rx_ready   = 1'b0;
        ovr_clr    = 1'b0;
        #1;
        test_reset();
        test_normal_read();
        test_read_id();
        test_partial_byte();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
